spi_mult_fsm: RTL and testbench
===============================

// Module: spi_mult_fsm
// PURPOSE
//   Control FSM for the SPI multiplier peripheral. Sequences operand shift-in over SPI,
//   starts the multiplier, loads the product into the MISO buffer and enables MISO output.
//   Runs entirely on the system clock clk; sclk, cs and done are sampled as data.
// PARAMETERS
//   LOAD_BITS     16   sclk rising edges counted in LOAD (both operands, serial)
//   MULT_TIMEOUT  255  clk cycles allowed in MULT before abort (only with FSMULT_TIMEOUT_EN)
// PORTS
//   clk           in   1  system clock, all state on rising edge
//   rst_n         in   1  asynchronous active-low reset
//   sclk          in   1  SPI serial clock (sampled)
//   cs            in   1  peripheral select, active-high (1 = transaction in progress)
//   done          in   1  multiplier finished, level
//   mode          out  2  shift-register mode: 00 hold, 01 serial shift-in, 10 parallel load, 11 serial shift-out
//   start         out  1  one-clk pulse: start multiplier
//   misobuffCNTL  out  1  1 = MISO buffer drives the line
//   actualstate   out  3  current state code
// BEHAVIOUR
//   - Input stage: sclk, cs, done each registered once on clk (sclk_q, cs_q, done_q);
//     sclk rise = sclk_q & ~sclk_q_d (second flop). All decisions use the registered copies.
//   - State codes: WAIT=3'd0, LOAD=3'd1, MULT=3'd2, MULTRES=3'd3, MISORESULT=3'd4; 5-7 unused -> WAIT next clk.
//   - Reset (rst_n=0, async): state=WAIT, bit counter=0, mode=00, start=0, misobuffCNTL=0.
//   - WAIT: cs_q=1 -> LOAD next clk (not qualified by sclk); counter cleared.
//   - LOAD: counter ++ per sclk rise; on rise making count==LOAD_BITS -> MULT.
//   - MULT: entry asserts start for exactly one clk; done_q=1 -> MULTRES.
//   - MULTRES: product parallel-loaded; -> MISORESULT on next sclk rise.
//   - MISORESULT: held until cs_q=0, then -> WAIT.
//   - cs_q=0 in any state other than WAIT -> WAIT next clk (abort); higher priority than all other transitions.
//   - done ignored outside MULT; done already high on MULT entry -> MULTRES one clk after start pulse.
//   - Outputs registered/Moore from state: WAIT 00/0, LOAD 01/0, MULT 00/0, MULTRES 10/0, MISORESULT 11/1
//     (mode/misobuffCNTL). actualstate = state register.
//   - Latency: cs edge -> LOAD within 2 clk; last LOAD sclk rise -> MULT within 3 clk; done -> MULTRES within 2 clk.
// CONFIGURATION
//   FSMULT_TIMEOUT_EN defined: cycle counter in MULT; reaching MULT_TIMEOUT clk cycles without done_q -> WAIT,
//     counter cleared on MULT exit. Undefined: MULT waits for done indefinitely; counter and parameter unused.
// TESTING
//   clk 20 ns, sclk 100 ns, rst_n pulsed low at t=0.
//   1 cs 0->1 at sclk rise -> actualstate=1 (LOAD), mode=01 by next sclk fall.
//   2 16 further sclk rises -> actualstate=2 (MULT), start high exactly 1 clk, mode=00.
//   3 done=1 at sclk fall -> actualstate=3 (MULTRES), mode=10 by next sclk fall; then 4 (MISORESULT),
//     mode=11, misobuffCNTL=1, held across 16+ sclk periods while cs=1.
//   4 cs->0 mid-LOAD (after 5 sclk rises) -> actualstate=0, outputs reset values; re-select restarts count at 0.
//   5 rst_n low during MISORESULT -> state 0, misobuffCNTL=0 immediately (no clk edge).
//   6 FSMULT_TIMEOUT_EN, MULT_TIMEOUT=10, done held 0 -> WAIT after 10 clk in MULT.

Source files
------------

// File: rtl/spi_mult_fsm.sv
// -----------------------------------------------------------------------------
// spi_mult_fsm
//   Control FSM for the SPI multiplier peripheral. It sequences the serial
//   shift-in of both operands, pulses the multiplier start, parallel-loads the
//   product into the MISO shift register and then hands the MISO line to that
//   register until the master deselects the peripheral.
//
//   sclk, cs and done are treated as plain data and registered on clk; every
//   decision is taken from the registered copies.
//
// Ports
//   clk          in   system clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   sclk         in   SPI serial clock (sampled)
//   cs           in   peripheral select, active-high
//   done         in   multiplier finished (level)
//   mode         out  shift-register mode: 00 hold, 01 serial in,
//                     10 parallel load, 11 serial out
//   start        out  one-clk pulse that starts the multiplier
//   misobuffCNTL out  1 = MISO buffer drives the line
//   actualstate  out  current state code
//
// Configuration
//   FSMULT_TIMEOUT_EN  when defined, MULT gives up and returns to WAIT after
//                      MULT_TIMEOUT clk cycles without done. When undefined,
//                      MULT waits for done indefinitely.
// -----------------------------------------------------------------------------
module spi_mult_fsm #(
    parameter int unsigned LOAD_BITS    = 16,
    parameter int unsigned MULT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs,
    input  logic       done,
    output logic [1:0] mode,
    output logic       start,
    output logic       misobuffCNTL,
    output logic [2:0] actualstate
);

    typedef enum logic [2:0] {
        ST_WAIT       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_MULT       = 3'd2,
        ST_MULTRES    = 3'd3,
        ST_MISORESULT = 3'd4
    } state_t;

    // Counter must be able to hold LOAD_BITS itself (value after the last rise).
    localparam int unsigned     CNT_W     = $clog2(LOAD_BITS + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_BITS);

    // Both parameters size counters; zero would leave nothing to count.
    generate
        if (LOAD_BITS < 1 || MULT_TIMEOUT < 1) begin : g_bad_params
            $error("spi_mult_fsm: LOAD_BITS and MULT_TIMEOUT must be at least 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Input stage
    // -------------------------------------------------------------------------
    logic r_sclk_q;
    logic r_sclk_q_d;
    logic r_cs_q;
    logic r_done_q;
    logic w_sclk_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_q   <= 1'b0;
            r_sclk_q_d <= 1'b0;
            r_cs_q     <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_sclk_q   <= sclk;
            r_sclk_q_d <= r_sclk_q;
            r_cs_q     <= cs;
            r_done_q   <= done;
        end
    end

    assign w_sclk_rise = r_sclk_q & ~r_sclk_q_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_inc;
    logic [1:0]       r_mode;
    logic             r_start;
    logic             r_miso_en;

    assign w_bit_cnt_inc = r_bit_cnt + 1'b1;

`ifdef FSMULT_TIMEOUT_EN
    localparam int unsigned     TO_W    = $clog2(MULT_TIMEOUT + 1);
    // Leaving on this count gives exactly MULT_TIMEOUT cycles spent in MULT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MULT_TIMEOUT - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_mult_timeout;

    assign w_mult_timeout = (r_to_cnt == TO_LAST);
`endif

    always_comb begin
        w_state_next = r_state;
        // Deselect aborts everything and outranks every other transition.
        if (r_state != ST_WAIT && !r_cs_q) begin
            w_state_next = ST_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_cs_q) begin
                        w_state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_sclk_rise && (w_bit_cnt_inc == LOAD_LAST)) begin
                        w_state_next = ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (r_done_q) begin
                        w_state_next = ST_MULTRES;
                    end
`ifdef FSMULT_TIMEOUT_EN
                    else if (w_mult_timeout) begin
                        w_state_next = ST_WAIT;
                    end
`endif
                end
                ST_MULTRES: begin
                    if (w_sclk_rise) begin
                        w_state_next = ST_MISORESULT;
                    end
                end
                ST_MISORESULT: begin
                    // Held until deselect, handled by the abort above.
                    w_state_next = ST_MISORESULT;
                end
                default: begin
                    w_state_next = ST_WAIT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State, counters and registered Moore outputs. Outputs are decoded from
    // the next state so they change on the same edge as actualstate.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT;
            r_bit_cnt <= '0;
            r_mode    <= 2'b00;
            r_start   <= 1'b0;
            r_miso_en <= 1'b0;
`ifdef FSMULT_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
        end else begin
            r_state <= w_state_next;

            // The counter only runs in LOAD; every other state (including the
            // mandatory pass through WAIT after an abort) clears it.
            if (r_state == ST_LOAD) begin
                if (w_sclk_rise) begin
                    r_bit_cnt <= w_bit_cnt_inc;
                end
            end else begin
                r_bit_cnt <= '0;
            end

`ifdef FSMULT_TIMEOUT_EN
            if (r_state == ST_MULT && w_state_next == ST_MULT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
`endif

            // Single-cycle pulse on the edge that enters MULT.
            r_start <= (w_state_next == ST_MULT) && (r_state != ST_MULT);

            case (w_state_next)
                ST_LOAD: begin
                    r_mode    <= 2'b01;
                    r_miso_en <= 1'b0;
                end
                ST_MULTRES: begin
                    r_mode    <= 2'b10;
                    r_miso_en <= 1'b0;
                end
                ST_MISORESULT: begin
                    r_mode    <= 2'b11;
                    r_miso_en <= 1'b1;
                end
                default: begin
                    r_mode    <= 2'b00;
                    r_miso_en <= 1'b0;
                end
            endcase
        end
    end

    assign mode         = r_mode;
    assign start        = r_start;
    assign misobuffCNTL = r_miso_en;
    assign actualstate  = r_state;

endmodule

// File: tb/tb_spi_mult_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_mult_fsm
//   Self-checking bench for spi_mult_fsm. Stimulus pushes the expected state
//   sequence into a queue; a monitor pops an entry whenever actualstate
//   changes and checks state, mode, misobuffCNTL and the start pulse.
//   With FSMULT_TIMEOUT_EN defined the MULT timeout is exercised (10 clk),
//   otherwise MULT is shown to wait for done indefinitely.
// -----------------------------------------------------------------------------
module tb_spi_mult_fsm;

    localparam int         LOAD_BITS = 16;
    localparam logic [2:0] S_WAIT    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_MULT    = 3'd2;
    localparam logic [2:0] S_MULTRES = 3'd3;
    localparam logic [2:0] S_MISO    = 3'd4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       sclk  = 1'b0;
    logic       cs    = 1'b0;
    logic       done  = 1'b0;
    logic [1:0] mode;
    logic       start;
    logic       misobuffCNTL;
    logic [2:0] actualstate;

    int         checks        = 0;
    int         errors        = 0;
    int         start_cycles  = 0;
    int         exp_starts    = 0;
    int         mult_run      = 0;
    int         last_mult_len = 0;
    logic [2:0] prev_state    = S_WAIT;
    logic [2:0] exp_q[$];

    spi_mult_fsm #(
        .LOAD_BITS   (LOAD_BITS),
        .MULT_TIMEOUT(10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .cs          (cs),
        .done        (done),
        .mode        (mode),
        .start       (start),
        .misobuffCNTL(misobuffCNTL),
        .actualstate (actualstate)
    );

    // clk 20 ns; sclk 100 ns, offset so its edges never meet a clk edge.
    always #10 clk = ~clk;
    initial begin
        #5;
        forever #50 sclk = ~sclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h t=%0t", tag, got, $time);
        end
    endtask

    function automatic logic [1:0] exp_mode(input logic [2:0] s);
        case (s)
            S_LOAD:    return 2'b01;
            S_MULTRES: return 2'b10;
            S_MISO:    return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    // Monitor: one scoreboard pop per observed state change.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (actualstate != prev_state) begin
                if (prev_state == S_MULT) last_mult_len = mult_run;
                mult_run = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_state", {29'd0, actualstate}, {29'd0, prev_state});
                end else begin
                    e = exp_q.pop_front();
                    chk("state", {29'd0, actualstate}, {29'd0, e});
                    chk("mode", {30'd0, mode}, {30'd0, exp_mode(e)});
                    chk("miso_en", {31'd0, misobuffCNTL}, {31'd0, (e == S_MISO)});
                    if (e == S_MULT) chk("start_on_entry", {31'd0, start}, 32'd1);
                end
                prev_state = actualstate;
            end else if (start) begin
                chk("start_spurious", {31'd0, start}, 32'd0);
            end
            if (actualstate == S_MULT) mult_run++;
            if (start) start_cycles++;
        end
    end

    // Wait up to max_clk clk edges for all pushed expectations to be observed.
    task automatic wait_drain(input string tag, input int max_clk);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_clk) begin
            @(posedge clk);
            n++;
            #11;
        end
        chk({tag, "_latency"}, exp_q.size(), 32'd0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    // Drives cs high on an sclk rise and expects LOAD within 2 clk.
    task automatic select(input string tag);
        @(posedge sclk);
        cs = 1'b1;
        exp_q.push_back(S_LOAD);
        wait_drain({tag, "_cs_to_load"}, 2);
    endtask

    // Counts LOAD_BITS sclk rises; MULT must not appear before the last one.
    task automatic shift_load(input string tag, input logic done_early);
        repeat (LOAD_BITS - 1) @(posedge sclk);
        @(negedge sclk);
        chk({tag, "_still_load"}, {29'd0, actualstate}, {29'd0, S_LOAD});
        if (done_early) done = 1'b1;
        exp_q.push_back(S_MULT);
        exp_starts++;
        if (done_early) exp_q.push_back(S_MULTRES);
        @(posedge sclk);
        wait_drain({tag, "_to_mult"}, done_early ? 4 : 3);
    endtask

    initial begin
        // Reset pulse near t=0
        #2 rst_n = 1'b0;
        #3;
        chk("rst_state", {29'd0, actualstate}, {29'd0, S_WAIT});
        chk("rst_mode", {30'd0, mode}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_miso", {31'd0, misobuffCNTL}, 32'd0);
        #35 rst_n = 1'b1;

        // Full transaction: LOAD, MULT, done, MULTRES, MISORESULT, hold, deselect
        select("t1");
        shift_load("t1", 1'b0);
        @(negedge sclk);
        done = 1'b1;
        exp_q.push_back(S_MULTRES);
        wait_drain("t1_done_to_multres", 2);
        exp_q.push_back(S_MISO);
        @(posedge sclk);
        wait_drain("t1_multres_to_miso", 2);
        done = 1'b0;
        repeat (18) @(posedge sclk);
        chk("t1_miso_hold_state", {29'd0, actualstate}, {29'd0, S_MISO});
        chk("t1_miso_hold_en", {31'd0, misobuffCNTL}, 32'd1);
        @(negedge sclk);
        cs = 1'b0;
        exp_q.push_back(S_WAIT);
        wait_drain("t1_miso_to_wait", 2);

        // Abort mid-LOAD after 5 rises, then reselect: count restarts at 0.
        // done is raised before MULT to cover the done-already-high case.
        select("t4");
        repeat (5) @(posedge sclk);
        @(negedge sclk);
        cs = 1'b0;
        exp_q.push_back(S_WAIT);
        wait_drain("t4_abort_load", 2);
        select("t4r");
        shift_load("t4r", 1'b1);
        chk("t4r_mult_len", last_mult_len, 32'd1);
        exp_q.push_back(S_MISO);
        @(posedge sclk);
        wait_drain("t4r_multres_to_miso", 2);
        done = 1'b0;

        // Asynchronous reset during MISORESULT, away from any clk edge
        @(posedge clk);
        #5;
        exp_q.push_back(S_WAIT);
        rst_n = 1'b0;
        cs    = 1'b0;
        #1;
        chk("t5_async_state", {29'd0, actualstate}, {29'd0, S_WAIT});
        chk("t5_async_miso", {31'd0, misobuffCNTL}, 32'd0);
        chk("t5_async_mode", {30'd0, mode}, 32'd0);
        #20 rst_n = 1'b1;
        wait_drain("t5_rst", 2);

        // MULT with done held low
        select("t6");
        shift_load("t6", 1'b0);
`ifdef FSMULT_TIMEOUT_EN
        exp_q.push_back(S_WAIT);
        exp_q.push_back(S_LOAD);
        wait_drain("t6_timeout", 14);
        chk("t6_mult_len", last_mult_len, 32'd10);
`else
        repeat (300) @(posedge clk);
        #1;
        chk("t6_mult_hold", {29'd0, actualstate}, {29'd0, S_MULT});
`endif
        cs = 1'b0;
        exp_q.push_back(S_WAIT);
        wait_drain("t6_deselect", 2);

        repeat (4) @(posedge clk);
        #1;
        chk("start_count", start_cycles, exp_starts);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
